register_pipe: RTL and testbench
================================

Name: register_pipe

Overview:
- Parametrised successor to the single-stage enable/clear data register.
- Provides a DEPTH-stage, WIDTH-bit register pipeline with a valid/ready handshake on both sides, plus global enable, synchronous flush and an occupancy count.
- Empty stages collapse: a bubble is filled whenever a stage is free, so a stalled output does not leave holes behind it.
- Used between datapath blocks wherever registered latency and backpressure are both needed.

Parameters:
- WIDTH, 8, data bit width (>=1).
- DEPTH, 2, number of register stages (>=1); also the unstalled latency in cycles.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden).

Ports:
- iClk  input  1  clock, rising edge.
- iRstN  input  1  reset, asynchronous, active-low.
- iEn  input  1  global enable; 0 freezes all state and both handshakes.
- iClr  input  1  synchronous flush; empties the pipeline.
- iValid  input  1  upstream data valid.
- oReady  output  1  pipeline can accept iData this cycle.
- iData  input  WIDTH  upstream data.
- oValid  output  1  oData holds a valid beat.
- iReady  input  1  downstream accepts oData this cycle.
- oData  output  WIDTH  data from the last stage.
- oCount  output  CNT_W  number of valid stages (0..DEPTH).

Behaviour:
- State per stage k (0 = input side, DEPTH-1 = output side): data_k[WIDTH], valid_k.
- Reset (iRstN low, asynchronous, takes effect immediately even mid-transfer):
  - all data_k = 0, all valid_k = 0, oCount = 0.
  - Outputs: oValid = 0, oData = 0. oReady = 0 while in reset.
- Ready chain (combinational):
  - rdy_DEPTH = iReady.
  - rdy_k = ~valid_k | rdy_(k+1).
  - oReady = iEn & ~iClr & rdy_0.
- Output handshake:
  - oValid = iEn & ~iClr & valid_(DEPTH-1).
  - oData = data_(DEPTH-1), ungated.
  - Pop occurs when oValid & iReady.
- Input handshake: push occurs when iValid & oReady.
- Per-cycle update, priority order: iClr > ~iEn > normal.
  - iClr=1 (regardless of iEn): all valid_k = 0, all data_k = 0, oCount = 0. No push or pop completes that cycle.
  - iEn=0, iClr=0: no state changes, no handshake completes. Resumes exactly where it stopped once iEn=1.
  - Normal operation:
    - Stage k (k>=1) loads data_(k-1) and valid_(k-1) when rdy_k = 1.
    - Stage 0 loads iData and iValid when rdy_0 = 1.
    - data_k loads only when the incoming valid is 1; otherwise data_k holds and valid_k clears.
- Latency:
  - A beat accepted in cycle t appears at oValid in cycle t+DEPTH if never stalled.
  - Throughput is one beat per cycle.
- oCount (registered): next = oCount + push - pop. Push and pop in the same cycle leave it unchanged.
- Full (oCount = DEPTH):
  - oReady = iReady.
  - A simultaneous pop and push is allowed when full.
- Empty: oValid = 0. A push into an empty pipe still takes DEPTH cycles to reach the output (no bypass).
- Ordering: beats leave in arrival order. No loss, no duplication.
- Invariant for assertions: oCount equals the population count of valid_k.

Decomposition:
- Shared define file entries:
  - default WIDTH and DEPTH values.
  - count-width helper macro (ceil log2 of DEPTH+1).
  - include guard matching the existing define-file style.
- Natural sub-module: register_pipe_stage.
  - Contents: one data+valid register with load and clear inputs, and its rdy_k term.
  - Instantiated DEPTH times by a generate loop.
  - oCount logic lives in the top level.

Test Plan (WIDTH=8, DEPTH=3):
1. Reset and idle: hold iRstN=0, then release with iEn=1, iClr=0 -> oValid=0, oData=0x00, oCount=0, oReady=1.
2. Streaming: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with iReady=1 -> 0x11 appears 3 cycles after its accept, then one beat per cycle in order. oCount rises 1, 2, 3 and stays 3 while streaming.
3. Backpressure (two phases):
   - iReady=0, offer 0x11..0x44 -> three accepted, oReady=0 after the third, oCount=3, oData=0x11 held.
   - Raise iReady -> 0x11 pops and 0x44 is accepted in the same cycle, oCount stays 3.
4. Bubble collapse: push 0xA0, idle 2 cycles, push 0xA1, keep iReady=0 -> 0xA0 in stage 2, 0xA1 in stage 1, oCount=2, oReady=1.
5. Flush: with the pipe full and iValid=1, pulse iClr for 1 cycle -> oReady=0 during the pulse and the beat is not accepted. Next cycle: oValid=0, oCount=0, oData=0x00.
6. Freeze and async reset:
   - Drop iEn for 4 cycles mid-stream -> oReady=0, oValid=0, state unchanged. After iEn=1 the sequence continues with no loss.
   - Assert iRstN mid-burst -> outputs go to zero without waiting for a clock edge.

Source files
------------

// File: rtl/register_pipe_pkg.sv
// register_pipe_pkg: shared defaults and the occupancy-count width helper for register_pipe
package register_pipe_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 2;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/register_pipe_stage.sv
// register_pipe_stage: one data+valid register of the pipe plus its ready-chain term
// clk_i/rst_n_i: clock, async active-low reset; en_i: advance allowed; clr_i: sync flush
// valid_i/data_i: beat from the previous stage; rdy_next_i: ready of the next stage
// valid_o/data_o: registered beat; rdy_o: this stage can take a beat this cycle
module register_pipe_stage
  import register_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             rdy_next_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             rdy_o
);
  logic             valid_q, valid_d, ld;
  logic [WIDTH-1:0] data_q, data_d;
  always_comb begin
    rdy_o   = ~valid_q | rdy_next_i;
    ld      = en_i & rdy_o;
    valid_d = clr_i ? 1'b0 : ld ? valid_i : valid_q;
    // a bubble moving in clears valid but keeps the old data
    data_d  = clr_i ? '0 : (ld & valid_i) ? data_i : data_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/register_pipe.sv
// register_pipe: DEPTH-stage WIDTH-bit collapsing register pipeline with valid/ready, enable, flush and count
// iClk/iRstN: clock, async active-low reset; iEn: global enable; iClr: sync flush
// iValid/oReady/iData: upstream handshake; oValid/iReady/oData: downstream handshake
// oCount: number of occupied stages
module register_pipe
  import register_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iEn,
  input  logic             iClr,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iData,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oData,
  output logic [CNT_W-1:0] oCount
);
  logic             run, push, pop;
  logic [DEPTH-1:0] valid, in_valid;
  logic [DEPTH:0]   rdy;
  logic [WIDTH-1:0] data [DEPTH];
  logic [WIDTH-1:0] in_data [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // iRstN is folded in so oReady reads 0 throughout reset
  assign run    = iRstN & iEn & ~iClr;
  assign rdy[DEPTH] = iReady;
  assign oReady = run & rdy[0];
  assign oValid = run & valid[DEPTH-1];
  assign oData  = data[DEPTH-1];
  assign push   = iValid & oReady;
  assign pop    = oValid & iReady;
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign in_valid[k] = iValid;
      assign in_data[k]  = iData;
    end else begin : g_body
      assign in_valid[k] = valid[k-1];
      assign in_data[k]  = data[k-1];
    end
    register_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk_i     (iClk),
      .rst_n_i   (iRstN),
      .en_i      (run),
      .clr_i     (iClr),
      .valid_i   (in_valid[k]),
      .data_i    (in_data[k]),
      .rdy_next_i(rdy[k+1]),
      .valid_o   (valid[k]),
      .data_o    (data[k]),
      .rdy_o     (rdy[k])
    );
  end
  always_comb cnt_d = iClr ? '0 : cnt_q + CNT_W'(push) - CNT_W'(pop);
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign oCount = cnt_q;
  a_count: assert property (@(posedge iClk) disable iff (!iRstN) cnt_q == CNT_W'($countones(valid)));
endmodule

// File: tb/tb_register_pipe.sv
module tb_register_pipe;
  localparam int W  = 8;
  localparam int D  = 3;
  localparam int CW = $clog2(D + 1);
  logic          iClk = 1'b0, iRstN = 1'b0, iEn = 1'b0, iClr = 1'b0, iValid = 1'b0, iReady = 1'b0;
  logic [W-1:0]  iData = '0;
  logic          oReady, oValid;
  logic [W-1:0]  oData;
  logic [CW-1:0] oCount;
  int n_tests = 0, n_fail = 0;

  register_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iClr(iClr), .iValid(iValid), .oReady(oReady),
    .iData(iData), .oValid(oValid), .iReady(iReady), .oData(oData), .oCount(oCount)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: the pipe is a FIFO of at most D beats. A beat accepted in
  // active cycle t is visible at the output from active cycle t+D, but never
  // before the cycle after its predecessor left. Frozen cycles do not count.
  logic [W-1:0] sb_q[$];
  int           acc_q[$];
  int           ecyc = 0, last_pop = -100;
  logic [W-1:0] last_out = '0;

  always @(negedge iClk) begin
    bit act, arr, ev, er;
    int hr;
    if (!iRstN) begin
      chk("rst_valid", 32'(oValid), 0);
      chk("rst_ready", 32'(oReady), 0);
      chk("rst_data", 32'(oData), 0);
      chk("rst_count", 32'(oCount), 0);
      sb_q.delete();
      acc_q.delete();
      last_pop = -100;
      last_out = '0;
    end else begin
      act = iEn && !iClr;
      arr = 1'b0;
      if (sb_q.size() > 0) begin
        hr  = (acc_q[0] + D > last_pop + 1) ? acc_q[0] + D : last_pop + 1;
        arr = ecyc >= hr;
      end
      ev = act && arr;
      er = act && (sb_q.size() < D || iReady);
      chk("valid", 32'(oValid), 32'(ev));
      chk("ready", 32'(oReady), 32'(er));
      chk("count", 32'(oCount), 32'(sb_q.size()));
      chk("data", 32'(oData), 32'(arr ? sb_q[0] : last_out));
      if (iClr) begin
        sb_q.delete();
        acc_q.delete();
        last_pop = -100;
        last_out = '0;
      end else if (act) begin
        if (ev && iReady) begin
          last_out = sb_q.pop_front();
          void'(acc_q.pop_front());
          last_pop = ecyc;
        end
        if (iValid && er) begin
          sb_q.push_back(iData);
          acc_q.push_back(ecyc);
        end
        ecyc++;
      end
    end
  end

  task automatic step(input logic en, input logic clr, input logic v, input logic r, input logic [W-1:0] d);
    @(posedge iClk);
    #1;
    iEn = en; iClr = clr; iValid = v; iReady = r; iData = d;
  endtask

  initial begin
    logic [W-1:0] s4 [4];
    s4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (3) step(1, 0, 0, 1, 0);
    @(posedge iClk); #1 iRstN = 1'b1;
    repeat (2) step(1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 1, s4[i]);
    repeat (6) step(1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, s4[i]);
    repeat (2) step(1, 0, 1, 0, 8'h44);
    step(1, 0, 1, 1, 8'h44);
    repeat (6) step(1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 8'hA0);
    repeat (2) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 8'hA1);
    repeat (3) step(1, 0, 0, 0, 0);
    repeat (6) step(1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 8'hB0 + W'(i));
    step(1, 1, 1, 0, 8'hBF);
    repeat (3) step(1, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) step(1, 0, 1, 1, 8'hC0 + W'(i));
    repeat (4) step(0, 0, 1, 1, 8'hCE);
    for (int i = 2; i < 5; i++) step(1, 0, 1, 1, 8'hC0 + W'(i));
    repeat (6) step(1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 8'hD0 + W'(i));
    @(posedge iClk);
    #1 iRstN = 1'b0;
    #1;
    chk("async_valid", 32'(oValid), 0);
    chk("async_ready", 32'(oReady), 0);
    chk("async_data", 32'(oData), 0);
    chk("async_count", 32'(oCount), 0);
    repeat (2) step(1, 0, 1, 1, 8'hEE);
    @(posedge iClk); #1 iRstN = 1'b1;
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, 1'($urandom), $urandom_range(0, 3) != 0, W'($urandom));
    repeat (8) step(1, 0, 0, 1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
